id_fetch_control: RTL



---
 rtl/id_fetch_control_if.sv | 31 +++
 rtl/id_fetch_control.sv | 104 ++++++++++
 2 files changed

// File: rtl/id_fetch_control_if.sv
// Fetch-side bundle between the fetch stage and the IF/ID control block.
// Fetch presents the instruction being fetched; decode returns PC enable and redirects.
interface id_fetch_control_if;
    logic [9:0]  if_pc_plus4;
    logic [31:0] if_instr;
    logic        pc_en;
    logic        branch_taken;
    logic [9:0]  branch_address;
    logic        jump;
    logic [9:0]  jump_address;

    modport master (
        output if_pc_plus4,
        output if_instr,
        input  pc_en,
        input  branch_taken,
        input  branch_address,
        input  jump,
        input  jump_address
    );

    modport slave (
        input  if_pc_plus4,
        input  if_instr,
        output pc_en,
        output branch_taken,
        output branch_address,
        output jump,
        output jump_address
    );
endinterface

// File: rtl/id_fetch_control.sv
// IF/ID pipeline register with ID-stage branch/jump resolution, hazard stalls,
// wrong-path squash and saturating stall/flush event counters.
module id_fetch_control (
    input  logic                     clk,
    input  logic                     reset,
    id_fetch_control_if.slave        fetch,
    input  logic [31:0]              rs_data,
    input  logic [31:0]              rt_data,
    input  logic                     ex_reg_write,
    input  logic                     ex_mem_read,
    input  logic [4:0]               ex_dest,
    input  logic                     mem_mem_read,
    input  logic [4:0]               mem_dest,
    output logic [31:0]              id_instr,
    output logic [9:0]               id_pc_plus4,
    output logic                     id_valid,
    output logic [4:0]               id_rs,
    output logic [4:0]               id_rt,
    output logic                     id_bubble,
    output logic [15:0]              stall_count,
    output logic [15:0]              flush_count
);
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;

    logic [5:0] opcode;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic       ex_match;
    logic       mem_match;
    logic       load_use;
    logic       branch_hazard;
    logic       stall;
    logic       redirect;

    assign opcode = id_instr[31:26];
    assign id_rs  = id_instr[25:21];
    assign id_rt  = id_instr[20:16];
    assign is_beq = (opcode == OP_BEQ);
    assign is_bne = (opcode == OP_BNE);
    assign is_j   = (opcode == OP_J);

    // A zero destination never matches, so r0 writes cannot create hazards.
    assign ex_match  = (ex_dest != 5'd0) && ((ex_dest == id_rs) || (ex_dest == id_rt));
    assign mem_match = (mem_dest != 5'd0) && ((mem_dest == id_rs) || (mem_dest == id_rt));

    assign load_use      = id_valid && ex_mem_read && ex_match;
    assign branch_hazard = id_valid && (is_beq || is_bne) &&
                           ((ex_reg_write && ex_match) || (mem_mem_read && mem_match));
    assign stall         = load_use || branch_hazard;

    always_comb begin
        fetch.branch_taken = 1'b0;
        fetch.jump         = 1'b0;
        if (id_valid && !stall) begin
            fetch.branch_taken = (is_beq && (rs_data == rt_data)) ||
                                 (is_bne && (rs_data != rt_data));
            fetch.jump         = is_j;
        end
    end

    // Targets always come from IF/ID; only the strobes above are qualified.
    assign fetch.branch_address = id_pc_plus4 + {id_instr[7:0], 2'b00};
    assign fetch.jump_address   = {id_instr[7:0], 2'b00};
    assign fetch.pc_en          = !stall;
    assign id_bubble            = stall || !id_valid;
    assign redirect             = fetch.branch_taken || fetch.jump;

    always_ff @(posedge clk) begin
        if (reset) begin
            id_instr    <= 32'd0;
            id_pc_plus4 <= 10'd0;
            id_valid    <= 1'b0;
        end else if (stall) begin
            id_instr    <= id_instr;
            id_pc_plus4 <= id_pc_plus4;
            id_valid    <= id_valid;
        end else if (redirect) begin
            id_instr    <= 32'd0;
            id_pc_plus4 <= fetch.if_pc_plus4;
            id_valid    <= 1'b0;
        end else begin
            id_instr    <= fetch.if_instr;
            id_pc_plus4 <= fetch.if_pc_plus4;
            id_valid    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= 16'd0;
            flush_count <= 16'd0;
        end else begin
            if (stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
            if (redirect && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
endmodule
